// File: rtl/psdsqrt_pkg.sv
// Shared constants and width helpers for the PSD square-root unit.
// Holds the default operand width, the reserved tuning value and the derived widths.
package psdsqrt_pkg;

  localparam int NBITSIN_DEF = 32;
  localparam int K_DEF       = 19;

  // Result width: one root bit per two radicand bits.
  function automatic int res_w(input int nbits);
    return nbits / 2;
  endfunction

  // Iteration counter width: holds 0..res_w-1 with one spare bit.
  function automatic int cnt_w(input int nbits);
    return $clog2(nbits / 2) + 1;
  endfunction

endpackage

// File: rtl/psdsqrt_step.sv
// One restoring square-root iteration: try setting the current mask bit in the root.
// Ports: i_x radicand, i_root/i_mask current state, o_next_root/o_next_mask next state.
module psdsqrt_step
  import psdsqrt_pkg::*;
#(
  parameter int NBITSIN = NBITSIN_DEF,
  localparam int RW = res_w(NBITSIN)
) (
  input  logic [NBITSIN-1:0] i_x,
  input  logic [RW-1:0]      i_root,
  input  logic [RW-1:0]      i_mask,
  output logic [RW-1:0]      o_next_root,
  output logic [RW-1:0]      o_next_mask
);

  logic [RW-1:0]      w_trial;
  logic [NBITSIN-1:0] w_trial_ext;
  logic [NBITSIN-1:0] w_sq;

  assign w_trial     = i_root | i_mask;
  assign w_trial_ext = {{RW{1'b0}}, w_trial};
  // An RW-bit value squared fits in 2*RW = NBITSIN bits.
  assign w_sq        = w_trial_ext * w_trial_ext;

  assign o_next_root = (i_x >= w_sq) ? w_trial : i_root;
  assign o_next_mask = i_mask >> 1;

endmodule

// File: rtl/psdsqrt.sv
// Sequential floor(sqrt(xin)), one root bit per clock, result loaded into sqrt on stop.
// Ports: clock, reset (sync, high), start/stop pulses, xin radicand, sqrt registered root.
module psdsqrt
  import psdsqrt_pkg::*;
#(
  parameter int NBITSIN = NBITSIN_DEF,
  parameter int k       = K_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NBITSIN-1:0]   xin,
  output logic [NBITSIN/2-1:0] sqrt
);

  localparam int RW = res_w(NBITSIN);
  localparam int CW = cnt_w(NBITSIN);
  localparam logic [CW-1:0] LAST = CW'(RW - 1);
  localparam logic [RW-1:0] MSB  = {1'b1, {(RW-1){1'b0}}};

  // Reserved tuning value; carried for compatibility only.
  localparam int unused_k = k;

  logic [NBITSIN-1:0] r_x;
  logic [RW-1:0]      r_root;
  logic [RW-1:0]      r_mask;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [RW-1:0]      r_sqrt;

  logic [RW-1:0]      w_next_root;
  logic [RW-1:0]      w_next_mask;

  psdsqrt_step #(
    .NBITSIN (NBITSIN)
  ) u_step (
    .i_x         (r_x),
    .i_root      (r_root),
    .i_mask      (r_mask),
    .o_next_root (w_next_root),
    .o_next_mask (w_next_mask)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_x    <= '0;
      r_root <= '0;
      r_mask <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_sqrt <= '0;
    end else begin
      // stop sees the pre-edge root, even when start restarts on this edge.
      if (stop) begin
        r_sqrt <= r_root;
      end
      if (start) begin
        r_x    <= xin;
        r_root <= '0;
        r_mask <= MSB;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_root <= w_next_root;
        r_mask <= w_next_mask;
        r_cnt  <= r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          r_busy <= 1'b0;
        end
      end
    end
  end

  assign sqrt = r_sqrt;

endmodule

// File: tb/tb_psdsqrt.sv
// Self-checking bench for psdsqrt: directed cases, a sweep and control corner cases.
// Expected roots are queued at stimulus time and popped when stop loads sqrt.
module tb_psdsqrt;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic [31:0] xin   = '0;
  logic [15:0] sqrt;

  int checks = 0;
  int errors = 0;
  int unsigned q[$];

  psdsqrt #(.NBITSIN(32), .k(19)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .xin   (xin),
    .sqrt  (sqrt)
  );

  always #5 clock = ~clock;

  // Independent floor-sqrt: float estimate, then integer fix-up.
  function automatic int unsigned gold(input logic [31:0] x);
    longint unsigned r;
    longint unsigned xl;
    xl = 64'(x);
    r  = 64'($rtoi($sqrt($itor(xl))));
    while (r * r > xl) r = r - 1;
    while ((r + 1) * (r + 1) <= xl) r = r + 1;
    return int'(r);
  endfunction

  // Partial root after n bit decisions, MSB first.
  function automatic int unsigned partial(input logic [31:0] x,
                                          input int n);
    longint unsigned root;
    longint unsigned t;
    root = 0;
    for (int i = 0; i < n; i++) begin
      t = root | (64'd1 << (15 - i));
      if (t * t <= 64'(x)) root = t;
    end
    return int'(root);
  endfunction

  task automatic check(input string tag, input int unsigned obs,
                       input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit st, input bit sp, input logic [31:0] x);
    start = st;
    stop  = sp;
    xin   = x;
    @(posedge clock);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pop_chk(input string tag);
    int unsigned e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0d expected=queued-value", tag, sqrt);
    end else begin
      e = q.pop_front();
      check(tag, 32'(sqrt), e);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] x,
                     input int unsigned exp);
    q.push_back(exp);
    cyc(1'b1, 1'b0, x);
    idle(16);
    cyc(1'b0, 1'b1, x);
    pop_chk(tag);
  endtask

  initial begin
    logic [31:0] rx;
    idle(2);
    check("reset", 32'(sqrt), 0);
    reset = 1'b0;
    idle(1);

    run("x123456", 32'd123456, 351);
    run("x0", 32'd0, 0);
    run("x1", 32'd1, 1);
    run("x3", 32'd3, 1);
    run("xFFFFFFFF", 32'hFFFF_FFFF, 65535);
    run("x65536", 32'd65536, 256);
    run("x65535", 32'd65535, 255);
    run("x4294836225", 32'd4294836225, 65535);

    for (int i = 0; i < 600; i++) begin
      run("sweep", 32'(i), gold(32'(i)));
    end
    for (int i = 0; i < 150; i++) begin
      rx = $urandom;
      run("rand", rx, gold(rx));
    end

    // Reset after five iterations clears sqrt and aborts.
    cyc(1'b1, 1'b0, 32'd123456);
    idle(5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("reset_mid", 32'(sqrt), 0);
    run("after_reset", 32'd10000, 100);

    // xin changes after the start edge are ignored.
    q.push_back(12);
    cyc(1'b1, 1'b0, 32'd144);
    cyc(1'b0, 1'b0, 32'd0);
    idle(15);
    cyc(1'b0, 1'b1, 32'd0);
    pop_chk("xin_change");
    q.push_back(12);
    cyc(1'b0, 1'b1, 32'd0);
    pop_chk("restop");

    // Early stops load partial roots without aborting.
    q.push_back(partial(32'd123456, 0));
    cyc(1'b1, 1'b0, 32'd123456);
    cyc(1'b0, 1'b1, 32'd123456);
    pop_chk("early_stop1");
    q.push_back(256);
    idle(7);
    cyc(1'b0, 1'b1, 32'd123456);
    pop_chk("early_stop8");
    q.push_back(partial(32'd123456, 16));
    idle(7);
    cyc(1'b0, 1'b1, 32'd123456);
    pop_chk("late_stop");

    // start during RUN restarts with the new operand.
    q.push_back(100);
    cyc(1'b1, 1'b0, 32'd123456);
    idle(5);
    cyc(1'b1, 1'b0, 32'd10000);
    idle(16);
    cyc(1'b0, 1'b1, 32'd0);
    pop_chk("abort_restart");

    // start and stop on the same edge: old root out, new root computed.
    q.push_back(351);
    cyc(1'b1, 1'b0, 32'd123456);
    idle(16);
    cyc(1'b1, 1'b1, 32'd144);
    pop_chk("start_stop_old");
    q.push_back(12);
    idle(16);
    cyc(1'b0, 1'b1, 32'd0);
    pop_chk("start_stop_new");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
